alu_cmd_sequencer: RTL and testbench

Command-side master for the 16-bit signed ALU datapath.
- Accepts operation commands over a valid/ready interface and drives the ALU operand and opcode inputs from registers.
- Captures the ALU's combinational result and flags one cycle later and returns them over a valid/ready response interface.
- Keeps an accumulator so chained operations can run without software re-supplying operand A.
- Sits between the command source (control FSM or testbench host) and the combinational ALU.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side master for the 16-bit signed ALU.
// It accepts one command, drives the ALU from registers for one cycle, and
// captures the result and flags. It then holds the response until the
// consumer takes it. An accumulator lets chained operations reuse the
// previous result as operand A.
//
// Handshake rule, used on both ports: a transfer happens on the rising edge
// where valid and ready are both 1. While valid is 1 it stays high and the
// payload stays stable until that transfer. Ready never depends on valid.
module alu_cmd_sequencer #(
  parameter int          WIDTH  = 16,
  parameter logic [3:0]  MAX_OP = 4'b1000,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_write_acc,
  input  logic             acc_clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             wacc_r;
  logic             err_r;
  logic             cmd_fire;
  logic             rsp_fire;
  logic             in_exec;

  // Ready is forced low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready = rst_n & (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign in_exec   = (state == EXEC);
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_op    = op_r;
  assign dbg_state = state;

  // Control FSM: IDLE -> EXEC (one ALU cycle) -> RESP (until consumed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cmd_fire) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (rsp_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register the command on acceptance. Operand A takes the accumulator as it
  // stands at this edge, so a same-cycle acc_clear does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      wacc_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (cmd_fire) begin
      op_r   <= cmd_op;
      a_r    <= cmd_use_acc ? acc : cmd_a;
      b_r    <= cmd_b;
      wacc_r <= cmd_write_acc;
      err_r  <= (cmd_op > MAX_OP);
    end
  end

  // Capture the ALU outputs at the end of EXEC. For an illegal opcode the
  // response is a fixed error pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (in_exec) begin
      if (err_r) begin
        rsp_result   <= '0;
        rsp_carry    <= 1'b0;
        rsp_overflow <= 1'b0;
        rsp_zero     <= 1'b1;
        rsp_err      <= 1'b1;
      end else begin
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carry;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
        rsp_err      <= 1'b0;
      end
    end
  end

  // Accumulator and sticky overflow. acc_clear wins over an EXEC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sticky_ovf <= 1'b0;
    end else if (acc_clear) begin
      acc        <= '0;
      sticky_ovf <= 1'b0;
    end else if (in_exec && !err_r) begin
      if (wacc_r) acc <= alu_result;
      sticky_ovf <= sticky_ovf | alu_overflow;
    end
  end

  // Count consumed responses; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer, with a behavioural stand-in for the
// combinational ALU.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_use_acc, cmd_write_acc, acc_clear;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carry, alu_overflow, alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_overflow, rsp_zero, rsp_err;
  logic [15:0] acc;
  logic        sticky_ovf;
  logic [15:0] op_count;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .cmd_write_acc(cmd_write_acc), .acc_clear(acc_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .acc(acc), .sticky_ovf(sticky_ovf),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ALU stand-in: 0=ADD, 1=SUB (carry=borrow), 8=INC A; any other code
  // returns A^B with carry and overflow set, so a forced error response is
  // visibly different from the raw ALU output.
  logic [16:0] t;
  always_comb begin
    t            = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd0: begin
        t            = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry    = t[16];
        alu_overflow = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'd1: begin
        t            = {1'b0, alu_a} - {1'b0, alu_b};
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'd8: begin
        t            = {1'b0, alu_a} + 17'd1;
        alu_carry    = t[16];
        alu_overflow = (alu_a == 16'h7FFF);
      end
      default: begin
        t            = {1'b0, alu_a ^ alu_b};
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
      end
    endcase
    alu_result = t[15:0];
    alu_zero   = (t[15:0] == 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command from a negedge and return at the negedge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ua, input logic wa);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_use_acc = ua; cmd_write_acc = wa;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Consume the pending response: one edge with rsp_ready high.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; cmd_write_acc = 1'b0; acc_clear = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_acc", {16'd0, acc}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rel_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);

    // ADD with signed overflow
    issue(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("add_exec_valid", {31'd0, rsp_valid}, 32'd0);
    check("add_exec_ready", {31'd0, cmd_ready}, 32'd0);
    check("add_alu_a", {16'd0, alu_a}, 32'h7FFF);
    check("add_alu_b", {16'd0, alu_b}, 32'h0001);
    @(negedge clk);
    check("add_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_result", {16'd0, rsp_result}, 32'h8000);
    check("add_ovf", {31'd0, rsp_overflow}, 32'd1);
    check("add_carry", {31'd0, rsp_carry}, 32'd0);
    check("add_zero", {31'd0, rsp_zero}, 32'd0);
    check("add_err", {31'd0, rsp_err}, 32'd0);
    check("add_sticky", {31'd0, sticky_ovf}, 32'd1);
    check("add_acc_untouched", {16'd0, acc}, 32'd0);
    take_rsp();
    check("add_after_valid", {31'd0, rsp_valid}, 32'd0);
    check("add_after_ready", {31'd0, cmd_ready}, 32'd1);
    check("add_count", {16'd0, op_count}, 32'd1);

    // Chaining through the accumulator (cmd_a must be ignored)
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    check("clr_sticky", {31'd0, sticky_ovf}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      issue(4'd8, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      @(negedge clk);
      check("chain_result", {16'd0, rsp_result}, i);
      take_rsp();
    end
    check("chain_acc", {16'd0, acc}, 32'h0003);
    check("chain_count", {16'd0, op_count}, 32'd4);

    // Backpressure on SUB 5-5
    rsp_ready = 1'b0;
    issue(4'd1, 16'h0005, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", {16'd0, rsp_result}, 32'h0000);
      check("bp_zero", {31'd0, rsp_zero}, 32'd1);
      check("bp_carry", {31'd0, rsp_carry}, 32'd0);
      check("bp_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_count", {16'd0, op_count}, 32'd4);
    end
    take_rsp();
    check("bp_after_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_after_count", {16'd0, op_count}, 32'd5);

    // Illegal opcode 1100 with write_acc requested
    issue(4'hC, 16'h1234, 16'h0000, 1'b0, 1'b1);
    check("ill_alu_op", {28'd0, alu_op}, 32'hC);
    @(negedge clk);
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_err", {31'd0, rsp_err}, 32'd1);
    check("ill_result", {16'd0, rsp_result}, 32'h0000);
    check("ill_zero", {31'd0, rsp_zero}, 32'd1);
    check("ill_carry", {31'd0, rsp_carry}, 32'd0);
    check("ill_ovf", {31'd0, rsp_overflow}, 32'd0);
    check("ill_acc", {16'd0, acc}, 32'h0003);
    check("ill_sticky", {31'd0, sticky_ovf}, 32'd0);
    take_rsp();
    check("ill_count", {16'd0, op_count}, 32'd6);

    // acc_clear during EXEC of an overflowing write_acc ADD
    issue(4'd0, 16'h4000, 16'h4000, 1'b0, 1'b1);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    check("cp_valid", {31'd0, rsp_valid}, 32'd1);
    check("cp_result", {16'd0, rsp_result}, 32'h8000);
    check("cp_ovf", {31'd0, rsp_overflow}, 32'd1);
    check("cp_acc", {16'd0, acc}, 32'h0000);
    check("cp_sticky", {31'd0, sticky_ovf}, 32'd0);
    take_rsp();
    check("cp_count", {16'd0, op_count}, 32'd7);

    // Reset during EXEC
    issue(4'd0, 16'h0001, 16'h0002, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_state", {30'd0, dbg_state}, 32'd0);
    check("mr_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("mr_valid_hold", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mr_ready", {31'd0, cmd_ready}, 32'd1);
    check("mr_acc", {16'd0, acc}, 32'd0);
    check("mr_count", {16'd0, op_count}, 32'd0);
    check("mr_alu_a", {16'd0, alu_a}, 32'd0);
    check("mr_result", {16'd0, rsp_result}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    issue(4'd0, 16'h0002, 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    check("mr_next_valid", {31'd0, rsp_valid}, 32'd1);
    check("mr_next_result", {16'd0, rsp_result}, 32'h0005);
    take_rsp();
    check("mr_next_count", {16'd0, op_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
